// File: rtl/lc3b_mem_responder_pkg.sv
// Shared LC-3b types: word, byte write mask and the memory responder state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lc3b_mem_state;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int LC3B_CNT_W = 4;

endpackage

// File: rtl/lc3b_mem_responder_array.sv
// Word storage: one synchronous read port and one byte-enabled synchronous write port, no reset.
module lc3b_mem_array
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 i_re,
    input  logic                 i_we,
    input  lc3b_mem_wmask        i_be,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  lc3b_word             i_wdata,
    output lc3b_word             o_rdata
);

    lc3b_word r_mem [2**ADDR_BITS];
    lc3b_word r_rdata;

    // Read and write on the same edge: the read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        if (i_we) begin
            if (i_be[0]) begin
                r_mem[i_addr][7:0] <= i_wdata[7:0];
            end
            if (i_be[1]) begin
                r_mem[i_addr][15:8] <= i_wdata[15:8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: request latch, fixed-latency FSM and optional out-of-range check.
// Optional feature macro: LC3B_MEM_OOR_ERR_EN (adds mem_error, suppresses out-of-range writes).
module lc3b_mem_responder
    import lc3b_types::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_word      mem_address,
    input  lc3b_word      mem_wdata,
    input  lc3b_mem_wmask mem_byte_enable,
    output logic          mem_resp,
`ifdef LC3B_MEM_OOR_ERR_EN
    output lc3b_word      mem_rdata,
    output logic          mem_error
`else
    output lc3b_word      mem_rdata
`endif
);

    lc3b_mem_state         r_state, w_state_nxt;
    logic [LC3B_CNT_W-1:0] r_cnt, w_cnt_nxt;
    lc3b_word              r_addr, r_wdata;
    lc3b_mem_wmask         r_mask;
    logic                  r_write;

    logic          w_req, w_commit, w_idle, w_oor, w_write;
    lc3b_word      w_addr, w_wdata, w_arr_rdata;
    lc3b_mem_wmask w_mask;

    assign w_req  = mem_read | mem_write;
    assign w_idle = (r_state == IDLE);

    // In IDLE the live inputs feed the array so a LATENCY=1 transaction commits on its accept edge.
    assign w_addr  = w_idle ? mem_address     : r_addr;
    assign w_wdata = w_idle ? mem_wdata       : r_wdata;
    assign w_mask  = w_idle ? mem_byte_enable : r_mask;
    assign w_write = w_idle ? mem_write       : r_write;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = '0;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = LC3B_CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= LC3B_CNT_W'(1)) begin
                    w_state_nxt = RESP;
                    w_cnt_nxt   = '0;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_idle && w_req) begin
                r_addr  <= mem_address;
                r_wdata <= mem_wdata;
                r_mask  <= mem_byte_enable;
                r_write <= mem_write;
            end
        end
    end

    lc3b_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .i_re    (w_commit),
        .i_we    (w_commit & w_write & ~w_oor),
        .i_be    (w_mask),
        .i_addr  (w_addr[ADDR_BITS:1]),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign mem_resp = (r_state == RESP);

`ifdef LC3B_MEM_OOR_ERR_EN
    logic r_err;
    logic w_unused_addr;

    assign w_oor         = |w_addr[15:ADDR_BITS+1];
    assign w_unused_addr = w_addr[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_commit & w_oor;
        end
    end

    assign mem_error = r_err;
    assign mem_rdata = (mem_resp && !r_err) ? w_arr_rdata : '0;
`else
    logic w_unused_addr;

    // Upper address bits are dropped: addresses wrap modulo capacity.
    assign w_oor         = 1'b0;
    assign w_unused_addr = ^{w_addr[0], w_addr[15:ADDR_BITS+1]};
    assign mem_rdata     = mem_resp ? w_arr_rdata : '0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed table, multi-cycle corner sequences, random vs. reference model.
module tb_lc3b_mem_responder;
    import lc3b_types::*;

    localparam int LAT   = 3;
    localparam int ABITS = 12;

    logic          clk;
    logic          reset;
    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    logic          mem_resp;
    lc3b_word      mem_rdata;
`ifdef LC3B_MEM_OOR_ERR_EN
    logic          mem_error;
`endif

    lc3b_mem_responder #(
        .ADDR_BITS (ABITS),
        .LATENCY   (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
`ifdef LC3B_MEM_OOR_ERR_EN
        .mem_rdata       (mem_rdata),
        .mem_error       (mem_error)
`else
        .mem_rdata       (mem_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [2**ABITS];
    bit          known   [2**ABITS];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_oor(input logic [15:0] a);
`ifdef LC3B_MEM_OOR_ERR_EN
        return (a[15:ABITS+1] != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [15:0] a);
        return int'(a[ABITS:1]);
    endfunction

    // One complete handshake; also checks latency, single-cycle resp, and updates the model.
    task automatic do_txn(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                          input logic [1:0] m, output logic [15:0] rdata, output bit err);
        int lat;
        bit seen;
        int ix;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = m;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_resp) seen = 1;
        end
        rdata = mem_rdata;
`ifdef LC3B_MEM_OOR_ERR_EN
        err = mem_error;
`else
        err = 1'b0;
`endif
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check(seen && lat == LAT, "latency", lat, LAT);
        @(posedge clk);
        #1;
        check(mem_resp == 1'b0, "resp_one_cycle", mem_resp, 0);
        if (wr && !is_oor(a)) begin
            ix = widx(a);
            if (m[0]) ref_mem[ix][7:0]  = wd[7:0];
            if (m[1]) ref_mem[ix][15:8] = wd[15:8];
            if (m == 2'b11) known[ix] = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] rd_val;
        bit          err;
        int          resp_cnt;
        int          cyc;
        bit          seen;

        for (int i = 0; i < 2**ABITS; i++) begin
            known[i]   = 1'b0;
            ref_mem[i] = '0;
        end

        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        reset           = 1'b1;

        vecs.push_back('{0, 1, 16'h0040, 16'h1234, 2'b11, 0, 16'h0000});
        vecs.push_back('{1, 0, 16'h0040, 16'h0000, 2'b11, 1, 16'h1234});
        vecs.push_back('{0, 1, 16'h0040, 16'hABCD, 2'b01, 0, 16'h0000});
        vecs.push_back('{1, 0, 16'h0040, 16'h0000, 2'b01, 1, 16'h12CD});
        vecs.push_back('{0, 1, 16'h0040, 16'hABCD, 2'b10, 0, 16'h0000});
        vecs.push_back('{1, 0, 16'h0040, 16'h0000, 2'b00, 1, 16'hABCD});
        vecs.push_back('{0, 1, 16'h0040, 16'h0000, 2'b00, 0, 16'h0000});
        vecs.push_back('{1, 0, 16'h0041, 16'h0000, 2'b10, 1, 16'hABCD});
        vecs.push_back('{0, 1, 16'h0010, 16'h5555, 2'b11, 0, 16'h0000});
        vecs.push_back('{1, 1, 16'h0010, 16'hAAAA, 2'b11, 1, 16'h5555});
        vecs.push_back('{1, 0, 16'h0010, 16'h0000, 2'b11, 1, 16'hAAAA});

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check(mem_resp == 1'b0, "reset_resp", mem_resp, 0);
        check(mem_rdata == 16'h0, "reset_rdata", mem_rdata, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        foreach (vecs[i]) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd_val, err);
            if (vecs[i].chk) check(rd_val == vecs[i].exp, $sformatf("vec%0d_rdata", i), rd_val, vecs[i].exp);
        end

        // Request held continuously: resp in cycles LAT, LAT+(LAT+1), ...
        mem_read    = 1'b1;
        mem_address = 16'h0040;
        resp_cnt    = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            seen = (k >= LAT) && ((k - LAT) % (LAT + 1) == 0);
            check(mem_resp == seen, $sformatf("hold_resp_c%0d", k), mem_resp, seen);
            if (seen) check(mem_rdata == 16'hABCD, "hold_rdata", mem_rdata, 16'hABCD);
        end
        mem_read = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        // Address change after accept is ignored
        mem_read    = 1'b1;
        mem_address = 16'h0040;
        @(posedge clk);
        #1;
        mem_address = 16'h0010;
        cyc  = 1;
        seen = mem_resp;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = mem_resp;
        end
        check(seen && cyc == LAT, "addr_change_lat", cyc, LAT);
        check(mem_rdata == 16'hABCD, "addr_change_rdata", mem_rdata, 16'hABCD);
        mem_read = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a write is in BUSY: aborted, no response, storage untouched
        do_txn(0, 1, 16'h0020, 16'h0001, 2'b11, rd_val, err);
        mem_write       = 1'b1;
        mem_address     = 16'h0020;
        mem_wdata       = 16'hFFFF;
        mem_byte_enable = 2'b11;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check(mem_resp == 1'b0 && mem_rdata == 16'h0, "abort_reset_vals", {mem_resp, mem_rdata}, 0);
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        resp_cnt = 0;
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_cnt++;
        end
        check(resp_cnt == 0, "abort_no_resp", resp_cnt, 0);
        do_txn(1, 0, 16'h0020, 16'h0000, 2'b11, rd_val, err);
        check(rd_val == 16'h0001, "abort_no_write", rd_val, 16'h0001);

        // Out-of-range address
        do_txn(0, 1, 16'h0000, 16'h7777, 2'b11, rd_val, err);
        do_txn(0, 1, 16'h4000, 16'h9999, 2'b11, rd_val, err);
`ifdef LC3B_MEM_OOR_ERR_EN
        check(err == 1'b1, "oor_error", err, 1);
        check(rd_val == 16'h0, "oor_rdata", rd_val, 0);
        do_txn(1, 0, 16'h0000, 16'h0000, 2'b11, rd_val, err);
        check(rd_val == 16'h7777, "oor_suppressed", rd_val, 16'h7777);
`else
        do_txn(1, 0, 16'h0000, 16'h0000, 2'b11, rd_val, err);
        check(rd_val == 16'h9999, "oor_wrap", rd_val, 16'h9999);
`endif

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            logic [15:0] a, wd, exp;
            logic [1:0]  m;
            int          op;
            bit          rd, wr, chk;
            op = int'($urandom_range(0, 2));
            rd = (op != 1);
            wr = (op != 0);
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            else                           a = 16'($urandom_range(0, 63));
            wd  = 16'($urandom);
            m   = 2'($urandom);
            chk = 1'b0;
            exp = '0;
            if (rd) begin
                if (is_oor(a)) begin
                    chk = 1'b1;
                end else if (known[widx(a)]) begin
                    chk = 1'b1;
                    exp = ref_mem[widx(a)];
                end
            end
            do_txn(rd, wr, a, wd, m, rd_val, err);
            if (chk) check(rd_val == exp, $sformatf("rand%0d_rdata@%0h", t, a), rd_val, exp);
`ifdef LC3B_MEM_OOR_ERR_EN
            check(err == is_oor(a), $sformatf("rand%0d_err", t), err, is_oor(a));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
